// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared encodings, bus widths and arbitration helpers for the
// instruction/data memory-port arbiter.
package cpu_mem_arbiter_pkg;

  // SRAM-like bus widths
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned SCNT_W = 4;

  // Arbiter sequencer states
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  // Access size encodings carried on the size field
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_e;

  // Transaction owner
  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_e;

  // Data has priority unless inst has already waited through the allowed
  // number of consecutive data grants.
  function automatic logic data_wins(input logic              inst_req,
                                     input logic              data_req,
                                     input logic [SCNT_W-1:0] scnt,
                                     input logic [SCNT_W-1:0] limit);
    return data_req && !(inst_req && (scnt == limit));
  endfunction

  // Saturating increment of the starvation counter
  function automatic logic [SCNT_W-1:0] scnt_sat_inc(input logic [SCNT_W-1:0] scnt);
    return (scnt == {SCNT_W{1'b1}}) ? scnt : scnt + SCNT_W'(1);
  endfunction

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// SRAM-like request/response bus. The requester side uses the master
// modport, the responder side uses the slave modport.
interface cpu_mem_arbiter_if;
  import cpu_mem_arbiter_pkg::*;

  logic              req;
  logic              wr;
  logic [SIZE_W-1:0] size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/cpu_mem_arbiter.sv
// Shares one SRAM-like memory port between the instruction fetch requester
// and the data requester. Data has priority, a starvation guard forces an
// inst grant after STARVE_LIMIT consecutive data grants while inst waits,
// and exactly one transaction is outstanding at any time.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  cpu_mem_arbiter_if.slave  inst,
  cpu_mem_arbiter_if.slave  data,
  cpu_mem_arbiter_if.master mem
);

  localparam logic [SCNT_W-1:0] STARVE_LIMIT_C = SCNT_W'(STARVE_LIMIT);

  arb_state_e        state_r;
  arb_owner_e        own_r;
  logic [SCNT_W-1:0] scnt_r;

  logic in_addr_s;
  logic in_data_s;
  logic own_data_s;
  logic any_req_s;
  logic grant_data_s;

  assign in_addr_s    = (state_r == ARB_ADDR);
  assign in_data_s    = (state_r == ARB_DATA);
  assign own_data_s   = (own_r == OWN_DATA);
  assign any_req_s    = inst.req | data.req;
  assign grant_data_s = data_wins(inst.req, data.req, scnt_r, STARVE_LIMIT_C);

  // Sequencer: arbitration in IDLE, owner latch and starvation bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ARB_IDLE;
      own_r   <= OWN_INST;
      scnt_r  <= {SCNT_W{1'b0}};
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (any_req_s) begin
            state_r <= ARB_ADDR;
            if (grant_data_s) begin
              own_r <= OWN_DATA;
              // Only a data grant that made inst wait counts toward starvation
              scnt_r <= inst.req ? scnt_sat_inc(scnt_r) : {SCNT_W{1'b0}};
            end else begin
              own_r  <= OWN_INST;
              scnt_r <= {SCNT_W{1'b0}};
            end
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_ADDR: begin
          if (mem.addr_ok) begin
            state_r <= ARB_DATA;
          end else begin
            state_r <= ARB_ADDR;
          end
        end
        ARB_DATA: begin
          if (mem.data_ok) begin
            state_r <= ARB_IDLE;
          end else begin
            state_r <= ARB_DATA;
          end
        end
        default: begin
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

  // Request mux: the owner's payload is presented only while in ADDR, so the
  // downstream port reads all-zero whenever no request is being offered.
  assign mem.req   = in_addr_s;
  assign mem.wr    = in_addr_s & (own_data_s ? data.wr : inst.wr);
  assign mem.size  = in_addr_s ? (own_data_s ? data.size  : inst.size)  : {SIZE_W{1'b0}};
  assign mem.addr  = in_addr_s ? (own_data_s ? data.addr  : inst.addr)  : {ADDR_W{1'b0}};
  assign mem.wdata = in_addr_s ? (own_data_s ? data.wdata : inst.wdata) : {DATA_W{1'b0}};

  // Response demux: handshakes reach only the owner and only in the state
  // where they are meaningful; stray or late pulses are dropped here.
  assign inst.addr_ok = in_addr_s & ~own_data_s & mem.addr_ok;
  assign data.addr_ok = in_addr_s &  own_data_s & mem.addr_ok;
  assign inst.data_ok = in_data_s & ~own_data_s & mem.data_ok;
  assign data.data_ok = in_data_s &  own_data_s & mem.data_ok;
  assign inst.rdata   = (in_data_s & ~own_data_s) ? mem.rdata : {DATA_W{1'b0}};
  assign data.rdata   = (in_data_s &  own_data_s) ? mem.rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: directed scenarios followed by
// randomized rounds predicted by a transaction-level grant model.
module tb_cpu_mem_arbiter;

  localparam int LIMIT = 4;

  logic clk;
  logic reset;

  cpu_mem_arbiter_if inst_if ();
  cpu_mem_arbiter_if data_if ();
  cpu_mem_arbiter_if mem_if ();

  cpu_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .inst  (inst_if),
    .data  (data_if),
    .mem   (mem_if)
  );

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Payload each requester is currently presenting (0 = inst, 1 = data)
  logic        exp_wr    [2];
  logic [1:0]  exp_size  [2];
  logic [31:0] exp_addr  [2];
  logic [31:0] exp_wdata [2];

  // Grant model: consecutive data grants made while inst was waiting
  int mdl_streak = 0;

  // Free-running clock
  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic raise(input logic who, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    exp_wr[who]    = wr;
    exp_size[who]  = size;
    exp_addr[who]  = addr;
    exp_wdata[who] = wdata;
    if (who) begin
      data_if.req = 1'b1; data_if.wr = wr; data_if.size = size;
      data_if.addr = addr; data_if.wdata = wdata;
    end else begin
      inst_if.req = 1'b1; inst_if.wr = wr; inst_if.size = size;
      inst_if.addr = addr; inst_if.wdata = wdata;
    end
  endtask

  task automatic drop(input logic who);
    if (who) data_if.req = 1'b0;
    else     inst_if.req = 1'b0;
  endtask

  task automatic chk_oks(input string tag, input logic ia, input logic id,
                         input logic da, input logic dd);
    chk({tag, ".inst_addr_ok"}, {31'd0, inst_if.addr_ok}, {31'd0, ia});
    chk({tag, ".inst_data_ok"}, {31'd0, inst_if.data_ok}, {31'd0, id});
    chk({tag, ".data_addr_ok"}, {31'd0, data_if.addr_ok}, {31'd0, da});
    chk({tag, ".data_data_ok"}, {31'd0, data_if.data_ok}, {31'd0, dd});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".m_req"},   {31'd0, mem_if.req},  32'd0);
    chk({tag, ".m_wr"},    {31'd0, mem_if.wr},   32'd0);
    chk({tag, ".m_size"},  {30'd0, mem_if.size}, 32'd0);
    chk({tag, ".m_addr"},  mem_if.addr,  32'd0);
    chk({tag, ".m_wdata"}, mem_if.wdata, 32'd0);
    chk_oks(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, ".inst_rdata"}, inst_if.rdata, 32'd0);
    chk({tag, ".data_rdata"}, data_if.rdata, 32'd0);
  endtask

  task automatic chk_payload(input string tag, input logic who);
    chk({tag, ".m_req"},   {31'd0, mem_if.req},  32'd1);
    chk({tag, ".m_wr"},    {31'd0, mem_if.wr},   {31'd0, exp_wr[who]});
    chk({tag, ".m_size"},  {30'd0, mem_if.size}, {30'd0, exp_size[who]});
    chk({tag, ".m_addr"},  mem_if.addr,  exp_addr[who]);
    chk({tag, ".m_wdata"}, mem_if.wdata, exp_wdata[who]);
  endtask

  // One complete transaction, entered in IDLE with the expected winner's req
  // high; aw/dw are the wait cycles before m_addr_ok / m_data_ok.
  task automatic do_txn(input logic who, input int aw, input int dw,
                        input logic [31:0] rd, input string tag);
    tick();
    chk_payload({tag, ".grant"}, who);
    for (int i = 0; i < aw; i++) begin
      chk_oks({tag, ".addr_wait"}, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_payload({tag, ".addr_hold"}, who);
    end
    mem_if.addr_ok = 1'b1;
    #1;
    chk_oks({tag, ".addr_ok"}, ~who, 1'b0, who, 1'b0);
    tick();
    mem_if.addr_ok = 1'b0;
    drop(who);
    #1;
    chk({tag, ".m_req_data"}, {31'd0, mem_if.req}, 32'd0);
    for (int i = 0; i < dw; i++) begin
      chk_oks({tag, ".data_wait"}, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    mem_if.data_ok = 1'b1;
    mem_if.rdata   = rd;
    #1;
    chk_oks({tag, ".data_ok"}, 1'b0, ~who, 1'b0, who);
    if (!exp_wr[who]) begin
      chk({tag, ".rdata"}, who ? data_if.rdata : inst_if.rdata, rd);
    end
    chk({tag, ".other_rdata"}, who ? inst_if.rdata : data_if.rdata, 32'd0);
    tick();
    mem_if.data_ok = 1'b0;
    mem_if.rdata   = 32'd0;
    #1;
    chk({tag, ".m_req_idle"}, {31'd0, mem_if.req}, 32'd0);
    chk_oks({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Model: data is granted unless inst has waited through LIMIT data grants
  function automatic logic mdl_pick_data(input logic ip, input logic dp);
    if (!dp) return 1'b0;
    if (!ip) return 1'b1;
    return (mdl_streak < LIMIT);
  endfunction

  initial begin
    logic ip;
    logic dp;
    logic w;
    int   kind;

    clk = 1'b0;
    reset = 1'b1;
    inst_if.req = 1'b1; inst_if.wr = 1'b1; inst_if.size = 2'd2;
    inst_if.addr = 32'hBFC0_0000; inst_if.wdata = 32'h1111_1111;
    data_if.req = 1'b1; data_if.wr = 1'b1; data_if.size = 2'd1;
    data_if.addr = 32'h8000_0000; data_if.wdata = 32'h2222_2222;
    mem_if.addr_ok = 1'b1; mem_if.data_ok = 1'b1; mem_if.rdata = 32'h5555_AAAA;

    // Reset state with every input active
    #2;
    chk_all_zero("reset");
    tick();
    inst_if.req = 1'b0; data_if.req = 1'b0;
    mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = 32'd0;
    tick();
    reset = 1'b0;

    // Single instruction read
    raise(1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 32'd0);
    do_txn(1'b0, 0, 1, 32'h3C08_0001, "inst_rd");

    // Simultaneous requests: data write first, then inst
    raise(1'b0, 1'b0, 2'd2, 32'hBFC0_0004, 32'd0);
    raise(1'b1, 1'b1, 2'd2, 32'h8000_0010, 32'hDEAD_BEEF);
    do_txn(1'b1, 0, 0, 32'h0, "simul_data");
    do_txn(1'b0, 0, 0, 32'h2408_0002, "simul_inst");

    // Starvation guard: both held high, grants D D D D I D D D D I D
    raise(1'b0, 1'b0, 2'd2, 32'hBFC0_0100, 32'd0);
    raise(1'b1, 1'b0, 2'd2, 32'h8000_0100, 32'd0);
    for (int g = 0; g < 11; g++) begin
      w = (g == 4 || g == 9) ? 1'b0 : 1'b1;
      do_txn(w, 0, 0, 32'hC0DE_0000 + 32'(g), $sformatf("starve%0d", g));
      if (g != 9 && g != 10) begin
        if (w) raise(1'b1, 1'b0, 2'd2, 32'h8000_0104 + 32'(g * 4), 32'd0);
        else   raise(1'b0, 1'b0, 2'd2, 32'hBFC0_0104 + 32'(g * 4), 32'd0);
      end
    end

    // Wait states on the address phase
    raise(1'b0, 1'b1, 2'd0, 32'h0000_0123, 32'h0000_00A5);
    do_txn(1'b0, 3, 0, 32'h0, "wait_addr");

    // Spurious handshakes while idle
    mem_if.addr_ok = 1'b1; mem_if.data_ok = 1'b1; mem_if.rdata = 32'hFFFF_FFFF;
    #1;
    chk({"spur.m_req"}, {31'd0, mem_if.req}, 32'd0);
    chk_oks("spur", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("spur.inst_rdata", inst_if.rdata, 32'd0);
    tick();
    mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = 32'd0;
    #1;
    chk("spur_after.m_req", {31'd0, mem_if.req}, 32'd0);
    raise(1'b1, 1'b0, 2'd1, 32'h8000_0202, 32'd0);
    do_txn(1'b1, 0, 0, 32'h0000_BEEF, "post_spur");

    // Reset in the middle of a data phase
    raise(1'b1, 1'b0, 2'd2, 32'h8000_0040, 32'd0);
    tick();
    chk("rst_mid.m_req", {31'd0, mem_if.req}, 32'd1);
    mem_if.addr_ok = 1'b1;
    tick();
    mem_if.addr_ok = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    tick();
    tick();
    reset = 1'b0;
    drop(1'b1);
    tick();
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'h1234_5678;
    #1;
    chk_oks("late_data_ok", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("late_data_ok.data_rdata", data_if.rdata, 32'd0);
    tick();
    mem_if.data_ok = 1'b0; mem_if.rdata = 32'd0;
    raise(1'b0, 1'b0, 2'd2, 32'hBFC0_0380, 32'd0);
    do_txn(1'b0, 0, 0, 32'h4200_0018, "post_reset");

    // Randomized rounds against the grant model
    mdl_streak = 0;
    for (int r = 0; r < 40; r++) begin
      kind = int'($urandom_range(0, 9));
      ip = (kind < 2) || (kind >= 4);
      dp = (kind >= 2);
      if (ip) raise(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom, $urandom);
      if (dp) raise(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom, $urandom);
      while (ip || dp) begin
        w = mdl_pick_data(ip, dp);
        if (w && ip) mdl_streak = (mdl_streak < 15) ? mdl_streak + 1 : 15;
        else         mdl_streak = 0;
        do_txn(w, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), $urandom,
               $sformatf("rnd%0d", r));
        if (w) dp = 1'b0;
        else   ip = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Shares one SRAM-like memory port between the fetch stage (instruction requester) and the execute/memory stages (data requester). Arbitrates with data priority plus a starvation guard, and keeps exactly one transaction outstanding. Routes the response back to whichever requester owns the transaction. Sits between the pipeline stages and the single external memory/bridge port.

## Interface
Parameters:
- STARVE_LIMIT, 4, consecutive data grants allowed while inst waits; next grant is then forced to inst (range 1–15)

Ports. Requester prefix is `inst_` or `data_`; the same set exists for each.
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- {p}_req  in  1  request valid; held with payload stable until {p}_addr_ok
- {p}_wr  in  1  1 = write, 0 = read
- {p}_size  in  2  0 = byte, 1 = half, 2 = word
- {p}_addr  in  32  byte address
- {p}_wdata  in  32  write data
- {p}_addr_ok  out  1  request accepted (1-cycle pulse)
- {p}_data_ok  out  1  response done (1-cycle pulse)
- {p}_rdata  out  32  read data, valid with {p}_data_ok
- m_req, m_wr, m_size, m_addr, m_wdata  out  1/1/2/32/32  downstream request
- m_addr_ok, m_data_ok  in  1  downstream handshakes
- m_rdata  in  32  downstream read data

## Operation
- FSM states: IDLE, ADDR, DATA. Owner register `own` (0 = inst, 1 = data). Starvation counter `scnt`, 4 bits.
- IDLE: if any req is asserted, latch the owner and go to ADDR.
  - Choice: data wins if data_req and NOT (inst_req && scnt == STARVE_LIMIT); otherwise inst wins.
  - On a data win with inst_req high: scnt++ (saturating).
  - On an inst win: scnt = 0.
  - On a data win with inst_req low: scnt = 0.
- ADDR:
  - m_req = 1; m_wr, m_size, m_addr and m_wdata mux the owner's inputs.
  - m_addr_ok is passed combinationally to the owner's addr_ok.
  - On m_addr_ok, go to DATA.
- DATA:
  - m_req = 0.
  - m_data_ok is passed combinationally to the owner's data_ok; m_rdata goes to the owner's rdata.
  - On m_data_ok, go to IDLE.
- The non-owner's addr_ok and data_ok are always 0.
- m_data_ok in IDLE or ADDR is ignored. m_addr_ok outside ADDR is ignored.
- Writes follow the same path; data_ok marks write completion and rdata is don't-care.
- A requester dropping req while in ADDR violates protocol. The arbiter still completes the transaction.

## Timing
- Reset (async assert) puts all outputs at 0:
  - state = IDLE, own = 0, scnt = 0
  - m_req = 0, m_wr = 0, m_size = 0, m_addr = 0, m_wdata = 0
  - all addr_ok, data_ok and rdata outputs = 0
- Request path:
  - Request seen in IDLE at cycle T, so m_req = 1 at T+1.
  - Earliest addr_ok is at T+1 (zero-wait m_addr_ok).
  - Earliest data_ok is at T+2.
  - Earliest next arbitration is in IDLE at T+3.
- Back-to-back throughput is at most 1 transaction per 3 cycles.
- Reset mid-operation (ADDR or DATA):
  - Transaction abandoned, return to IDLE.
  - A late m_data_ok after reset is dropped and never reaches a requester.
- Simultaneous inst_req and data_req in IDLE are resolved by the rule above. No request is lost; the loser keeps req high.
- scnt updates only on the IDLE→ADDR transition.

## Structure
- Shared header (mycpu.h):
  - FSM state encodings (ARB_IDLE = 2'd0, ARB_ADDR = 2'd1, ARB_DATA = 2'd2)
  - size encodings
  - SRAM-like bus width macros
- Single module, no sub-module.
  - Request mux and response demux are inline assigns.
  - FSM, own and scnt share one async-reset always block.

## Test plan
- Single inst read:
  - Stimulus: inst_req at T with addr 0xBFC00000; m_addr_ok at T+1; m_data_ok at T+3 with m_rdata 0x3C080001.
  - Required: m_addr = 0xBFC00000 at T+1; inst_addr_ok = 1 at T+1; inst_data_ok = 1 and inst_rdata = 0x3C080001 at T+3; data_* outputs stay 0 throughout.
- Simultaneous requests:
  - Stimulus: inst_req and data_req (write, addr 0x80000010, wdata 0xDEADBEEF, size 2) both high in IDLE.
  - Required: data granted first, m_wr = 1; inst granted after data_data_ok.
- Starvation guard:
  - Stimulus: data_req and inst_req held high continuously, STARVE_LIMIT = 4.
  - Required: grants go data ×4, then inst, then data; scnt returns to 0 after the inst grant.
- Wait states:
  - Stimulus: m_addr_ok delayed 3 cycles.
  - Required: m_req and payload stay stable through all 3 cycles; owner addr_ok pulses exactly once.
- Reset mid-DATA:
  - Stimulus: assert reset while in DATA; release; then pulse m_data_ok.
  - Required: all outputs 0 immediately on reset; no data_ok reaches either requester; next request served normally.
- Spurious handshakes:
  - Stimulus: m_data_ok and m_addr_ok pulsed while in IDLE.
  - Required: no addr_ok or data_ok outputs; state stays IDLE.
